marquee_controller: RTL

MARQUEE_CONTROLLER -- requirements
Module: marquee_controller

---
 rtl/marquee_controller_pkg.sv | 23 ++
 rtl/ascii_to_seg7.sv | 58 +++++
 rtl/step_tick_gen.sv | 49 ++++
 rtl/marquee_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/marquee_controller_pkg.sv
// Shared types and constants for the marquee controller: scroll modes, bounce
// direction, blank/space codes and the selectable step rates.
package marquee_controller_pkg;

  typedef enum logic [1:0] {
    SCROLL_L = 2'd0,
    SCROLL_R = 2'd1,
    BOUNCE   = 2'd2,
    STATIC   = 2'd3
  } mode_t;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } dir_t;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Step rate in Hz, indexed by the speed input.
  localparam int unsigned RATE_HZ [4] = '{1, 2, 5, 10};

endpackage

// File: rtl/ascii_to_seg7.sv
// ASCII to active-low seven-segment converter (bit order gfedcba).
// Letters are case-insensitive; anything unsupported shows blank.
module ascii_to_seg7 (
  input  logic [7:0] ascii,
  output logic [6:0] seg
);

  logic [7:0] ch;
  logic [6:0] lit;

  always_comb begin
    ch = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) ch = ascii - 8'h20;
    lit = 7'h00;
    case (ch)
      "-": lit = 7'h40;
      "0": lit = 7'h3F;
      "1": lit = 7'h06;
      "2": lit = 7'h5B;
      "3": lit = 7'h4F;
      "4": lit = 7'h66;
      "5": lit = 7'h6D;
      "6": lit = 7'h7D;
      "7": lit = 7'h07;
      "8": lit = 7'h7F;
      "9": lit = 7'h6F;
      "A": lit = 7'h77;
      "B": lit = 7'h7C;
      "C": lit = 7'h39;
      "D": lit = 7'h5E;
      "E": lit = 7'h79;
      "F": lit = 7'h71;
      "G": lit = 7'h3D;
      "H": lit = 7'h76;
      "I": lit = 7'h30;
      "J": lit = 7'h1E;
      "K": lit = 7'h75;
      "L": lit = 7'h38;
      "M": lit = 7'h37;
      "N": lit = 7'h54;
      "O": lit = 7'h3F;
      "P": lit = 7'h73;
      "Q": lit = 7'h67;
      "R": lit = 7'h50;
      "S": lit = 7'h6D;
      "T": lit = 7'h78;
      "U": lit = 7'h3E;
      "V": lit = 7'h1C;
      "W": lit = 7'h2A;
      "X": lit = 7'h76;
      "Y": lit = 7'h6E;
      "Z": lit = 7'h5B;
      default: lit = 7'h00;
    endcase
    seg = ~lit;
  end

endmodule

// File: rtl/step_tick_gen.sv
// Step divider: counts 0..CLK_HZ/rate-1 and strobes step_tick at terminal count.
// Restarts on clear or any change of speed; holds while hold is high.
module step_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       step_tick
);
  import marquee_controller_pkg::*;

  localparam int CntW = $clog2(CLK_HZ);

  logic [CntW-1:0] count_q, count_d, term;
  logic [1:0]      speed_q;
  logic            restart;

  always_comb begin
    case (speed)
      2'd0:    term = CntW'(CLK_HZ / RATE_HZ[0] - 1);
      2'd1:    term = CntW'(CLK_HZ / RATE_HZ[1] - 1);
      2'd2:    term = CntW'(CLK_HZ / RATE_HZ[2] - 1);
      default: term = CntW'(CLK_HZ / RATE_HZ[3] - 1);
    endcase
  end

  assign restart   = clear || (speed != speed_q);
  assign step_tick = !restart && !hold && (count_q >= term);

  always_comb begin
    count_d = count_q + CntW'(1);
    if (restart || step_tick) count_d = '0;
    else if (hold)            count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      speed_q <= speed;
    end else begin
      count_q <= count_d;
      speed_q <= speed;
    end
  end

endmodule

// File: rtl/marquee_controller.sv
// Scrolling seven-segment marquee: message buffer, window position FSM
// (scroll left/right, bounce, static) and registered per-digit segment output.
module marquee_controller #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NUM_DISPLAYS = 6,
  parameter int MSG_MAX      = 32,
  parameter int CHAR_WIDTH   = 8
) (
  input  logic                        clk_50mhz,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(MSG_MAX)-1:0]  wr_addr,
  input  logic [CHAR_WIDTH-1:0]       wr_data,
  input  logic [$clog2(MSG_MAX):0]    msg_len,
  input  logic [1:0]                  mode,
  input  logic [1:0]                  speed,
  input  logic                        pause,
  output logic [7*NUM_DISPLAYS-1:0]   hex_segments,
  output logic [$clog2(MSG_MAX)-1:0]  window_pos,
  output logic                        wrap_pulse
);
  import marquee_controller_pkg::*;

  localparam int AW = $clog2(MSG_MAX);
  localparam int LW = AW + 1;
  localparam int SW = LW + 1;

  logic [CHAR_WIDTH-1:0] msg_buf_q [MSG_MAX];
  logic [AW-1:0]         pos_q, pos_d;
  dir_t                  dir_q, dir_d;
  logic                  wrap_q, wrap_d;
  logic [1:0]            mode_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         pos_ext, lim;
  logic                  cfg_change, step_tick;
  mode_t                 mode_sel;
  logic [SW-1:0]         sum;
  logic [AW-1:0]         rd_idx  [NUM_DISPLAYS];
  logic [6:0]            seg_raw [NUM_DISPLAYS];

  assign mode_sel   = mode_t'(mode);
  assign cfg_change = (mode != mode_q) || (msg_len != len_q);
  assign pos_ext    = {1'b0, pos_q};
  assign lim        = msg_len - LW'(NUM_DISPLAYS);
  assign window_pos = pos_q;
  assign wrap_pulse = wrap_q;

  step_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_step_tick_gen (
    .clk       (clk_50mhz),
    .reset     (reset),
    .clear     (cfg_change),
    .hold      (pause),
    .speed     (speed),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      for (int i = 0; i < MSG_MAX; i++) msg_buf_q[i] <= CHAR_WIDTH'(SPACE);
    end else if (wr_en && (int'(wr_addr) < MSG_MAX)) begin
      msg_buf_q[wr_addr] <= wr_data;
    end
  end

  // A config change outranks a coincident step so the new pass starts cleanly at 0.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (cfg_change || msg_len == '0) begin
      pos_d = '0;
      dir_d = FWD;
    end else if (step_tick) begin
      case (mode_sel)
        SCROLL_L: begin
          if (pos_ext == msg_len - LW'(1)) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + AW'(1);
          end
        end
        SCROLL_R: begin
          if (pos_q == '0) begin
            pos_d  = AW'(msg_len - LW'(1));
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - AW'(1);
          end
        end
        BOUNCE: begin
          if (msg_len <= LW'(NUM_DISPLAYS)) begin
            pos_d = '0;
            dir_d = FWD;
          end else if (dir_q == FWD) begin
            pos_d = pos_q + AW'(1);
            if (pos_ext + LW'(1) == lim) begin
              dir_d  = REV;
              wrap_d = 1'b1;
            end
          end else begin
            pos_d = pos_q - AW'(1);
            if (pos_q == AW'(1)) begin
              dir_d  = FWD;
              wrap_d = 1'b1;
            end
          end
        end
        STATIC: pos_d = pos_q;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      pos_q  <= '0;
      dir_q  <= FWD;
      wrap_q <= 1'b0;
      mode_q <= mode;
      len_q  <= msg_len;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      mode_q <= mode;
      len_q  <= msg_len;
    end
  end

  // Modulo by repeated subtraction; pos < msg_len so NUM_DISPLAYS passes suffice.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      sum = {1'b0, pos_ext} + SW'(NUM_DISPLAYS - 1 - i);
      for (int j = 0; j < NUM_DISPLAYS; j++) begin
        if (sum >= {1'b0, msg_len}) sum = sum - {1'b0, msg_len};
      end
      rd_idx[i] = AW'(sum);
    end
  end

  for (genvar g = 0; g < NUM_DISPLAYS; g++) begin : g_digit
    ascii_to_seg7 u_conv (
      .ascii (8'(msg_buf_q[rd_idx[g]])),
      .seg   (seg_raw[g])
    );
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset || msg_len == '0) begin
      hex_segments <= {NUM_DISPLAYS{BLANK_SEG}};
    end else begin
      for (int i = 0; i < NUM_DISPLAYS; i++) hex_segments[7*i +: 7] <= seg_raw[i];
    end
  end

endmodule
